// File: rtl/fetch_pkg.sv
// Shared state encoding and constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int          INSTR_W          = 16;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        WAIT   = 3'd1,
        HOLD   = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/addsub_16bit.sv
// 16-bit adder/subtractor; subtraction is a + ~b + 1, results wrap modulo 2^16.
module addsub_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b_in,
    input  logic        is_sub,
    output logic [15:0] result
);

    logic [15:0] b_eff;

    assign b_eff  = is_sub ? ~b_in : b_in;
    assign result = a + b_eff + {15'd0, is_sub};

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, keeps one request in flight to
// instruction memory, and applies redirect, halt-drain and IF/ID stall.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_if,
    input  logic               redirect,
    input  logic [15:0]        redirect_pc,
    input  logic               hlt_id,
    output logic               imem_req,
    output logic [15:0]        imem_addr,
    input  logic               imem_ready,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [15:0]        if_pc,
    output logic [15:0]        if_pc_plus2,
    output logic               flush_ifid,
    output logic               halted
);

    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES);

    fetch_state_e       state_q;
    logic [15:0]        pc_q;
    logic [15:0]        req_pc_q;
    logic [15:0]        req_pc_plus2_q;
    logic [INSTR_W-1:0] hold_q;
    logic               squash_q;
    logic [2:0]         cnt_q;

    logic [15:0] pc_inc_d;

    logic is_fetch;
    logic is_wait;
    logic is_hold;
    logic is_halted;
    logic redirect_eff;
    logic halt_eff;
    logic req_live;
    logic resp_usable;
    logic deliver_wait;
    logic deliver_hold;

    addsub_16bit u_pc_inc (
        .a      (pc_q),
        .b_in   (16'h0002),
        .is_sub (1'b0),
        .result (pc_inc_d)
    );

    assign is_fetch  = (state_q == FETCH);
    assign is_wait   = (state_q == WAIT);
    assign is_hold   = (state_q == HOLD);
    assign is_halted = (state_q == HALTED);

    // Redirect outranks halt; both are ignored once halted.
    assign redirect_eff = redirect && !is_halted;
    assign halt_eff     = hlt_id && !redirect && (is_fetch || is_wait || is_hold);

    // A halting cycle must not issue a new request: the PC is frozen from here.
    assign req_live = is_fetch && !halt_eff;

    assign resp_usable  = is_wait && imem_valid && !squash_q && !redirect && !hlt_id;
    assign deliver_wait = resp_usable && !stall_if;
    assign deliver_hold = is_hold && !stall_if && !redirect && !hlt_id;

    assign imem_req    = !rst && req_live;
    assign imem_addr   = rst ? 16'h0000 : pc_q;
    assign if_valid    = !rst && (deliver_wait || deliver_hold);
    assign if_instr    = rst ? '0 : (is_hold ? hold_q : imem_instr);
    assign if_pc       = rst ? 16'h0000 : req_pc_q;
    assign if_pc_plus2 = rst ? 16'h0000 : req_pc_plus2_q;
    assign flush_ifid  = !rst && (redirect_eff || halt_eff);
    assign halted      = !rst && is_halted;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= FETCH;
            pc_q           <= RESET_PC;
            req_pc_q       <= 16'h0000;
            req_pc_plus2_q <= 16'h0000;
            hold_q         <= '0;
            squash_q       <= 1'b0;
            cnt_q          <= 3'd0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (redirect) begin
                        pc_q <= redirect_pc;
                        // A request accepted in the redirect cycle is stale.
                        if (imem_ready) begin
                            state_q  <= WAIT;
                            squash_q <= 1'b1;
                        end
                    end else if (hlt_id) begin
                        cnt_q   <= DRAIN_INIT;
                        state_q <= DRAIN;
                    end else if (imem_ready) begin
                        req_pc_q       <= pc_q;
                        req_pc_plus2_q <= pc_inc_d;
                        pc_q           <= pc_inc_d;
                        state_q        <= WAIT;
                    end
                end

                WAIT: begin
                    if (redirect) begin
                        pc_q <= redirect_pc;
                        if (imem_valid) begin
                            squash_q <= 1'b0;
                            state_q  <= FETCH;
                        end else begin
                            squash_q <= 1'b1;
                        end
                    end else if (hlt_id) begin
                        // The in-flight response still arrives, but DRAIN ignores it.
                        squash_q <= 1'b0;
                        cnt_q    <= DRAIN_INIT;
                        state_q  <= DRAIN;
                    end else if (imem_valid) begin
                        if (squash_q) begin
                            squash_q <= 1'b0;
                            state_q  <= FETCH;
                        end else if (stall_if) begin
                            hold_q  <= imem_instr;
                            state_q <= HOLD;
                        end else begin
                            state_q <= FETCH;
                        end
                    end
                end

                HOLD: begin
                    if (redirect) begin
                        pc_q    <= redirect_pc;
                        state_q <= FETCH;
                    end else if (hlt_id) begin
                        cnt_q   <= DRAIN_INIT;
                        state_q <= DRAIN;
                    end else if (!stall_if) begin
                        state_q <= FETCH;
                    end
                end

                DRAIN: begin
                    if (redirect) begin
                        pc_q    <= redirect_pc;
                        cnt_q   <= 3'd0;
                        state_q <= FETCH;
                    end else if (cnt_q <= 3'd1) begin
                        cnt_q   <= 3'd0;
                        state_q <= HALTED;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end

                HALTED: begin
                    state_q <= HALTED;
                end

                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

endmodule
